// File: rtl/wb_fetch_master_if.sv
// Single-beat read bus between the fetch unit and word-addressed slaves.
// The master drives address/strobe; the slave returns data with a one-cycle ack.
interface wb_fetch_master_if;
  logic [29:0] adr_o;
  logic        stb_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output adr_o,
    output stb_o,
    input  dat_i,
    input  ack_i
  );

  modport slave (
    input  adr_o,
    input  stb_o,
    output dat_i,
    output ack_i
  );
endinterface

// File: rtl/wb_fetch_master.sv
// Instruction fetch bus initiator with prefetch FIFO, redirect and
// bus timeout; one read outstanding at most.
module wb_fetch_master #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  wb_fetch_master_if.master bus,
  input  logic              redirect_i,
  input  logic [31:0]       target_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    ERR
  } state_t;

  state_t        state;
  logic [29:0]   adr;
  logic [29:0]   tgt;
  logic [31:0]   mem_d [DEPTH];
  logic [29:0]   mem_a [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_nx;
  logic [TW-1:0] tmo;
  logic          push;
  logic          pop;
  logic          room;
  logic          tmo_hit;
  logic          unused_tgt;

  assign unused_tgt = ^target_i[1:0];

  assign bus.adr_o = adr;
  assign bus.stb_o = (state == REQ) || (state == DISCARD);

  assign err_o   = (state == ERR);
  assign valid_o = (occ != '0) && !err_o;
  assign instr_o = mem_d[rd_ptr];
  assign pc_o    = {mem_a[rd_ptr], 2'b00};

  // A redirect cancels both sides of the FIFO in the same cycle.
  assign push   = (state == REQ) && bus.ack_i && !redirect_i;
  assign pop    = valid_o && ready_i && !redirect_i;
  assign occ_nx = occ + OW'(push) - OW'(pop);
  assign room   = occ_nx < FULL;

  assign tmo_hit = (TIMEOUT != 0) && bus.stb_o && !bus.ack_i &&
                   (32'(tmo) + 32'd1 >= TIMEOUT);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_d[wr_ptr] <= bus.dat_i;
      mem_a[wr_ptr] <= adr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      adr    <= RESET_ADDR[31:2];
      tgt    <= RESET_ADDR[31:2];
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      tmo    <= '0;
    end else begin
      if (bus.stb_o && !bus.ack_i && TIMEOUT != 0) begin
        tmo <= tmo + TW'(1);
      end else begin
        tmo <= '0;
      end

      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        occ <= occ_nx;
      end

      unique case (state)
        IDLE: begin
          if (redirect_i) begin
            state <= REQ;
            adr   <= target_i[31:2];
          end else if (room) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (redirect_i && bus.ack_i) begin
            adr <= target_i[31:2];
          end else if (redirect_i) begin
            // Address must stay put until the slave answers.
            state <= DISCARD;
            tgt   <= target_i[31:2];
          end else if (bus.ack_i) begin
            adr <= adr + 30'd1;
            if (!room) state <= IDLE;
          end else if (tmo_hit) begin
            state <= ERR;
          end
        end
        DISCARD: begin
          if (bus.ack_i) begin
            state <= REQ;
            adr   <= redirect_i ? target_i[31:2] : tgt;
          end else if (redirect_i) begin
            tgt <= target_i[31:2];
          end else if (tmo_hit) begin
            state <= ERR;
          end
        end
        ERR: begin
          if (redirect_i) begin
            state <= REQ;
            adr   <= target_i[31:2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
